// File: rtl/pin_pkg.sv
// Shared types and key codes for the PIN entry path.
// pinPac_t is the bundle handed to update_master.pin_in.
package pin_pkg;

   typedef struct packed {
      logic       status;
      logic [3:0] digit1;
      logic [3:0] digit2;
      logic [3:0] digit3;
      logic [3:0] digit4;
   } pinPac_t;

   localparam logic [3:0] KEY_STAR      = 4'hA;
   localparam logic [3:0] KEY_HASH      = 4'hB;
   localparam logic [3:0] DIGIT_INVALID = 4'hF;

   localparam pinPac_t PIN_CLEAR = '{
      status: 1'b0,
      digit1: DIGIT_INVALID,
      digit2: DIGIT_INVALID,
      digit3: DIGIT_INVALID,
      digit4: DIGIT_INVALID
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_SUBMIT
   } state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/pin_idle_timer.sv
// Saturating idle counter for the PIN collector.
// Expires once the count reaches LIMIT-1; never wraps.
module pin_idle_timer #(
   parameter int unsigned LIMIT = 5000,
   parameter int unsigned W     = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_cnt_en,
   output logic o_expire
);

   logic [W-1:0] r_count;

   assign o_expire = (r_count >= W'(LIMIT - 1));

   // Count while enabled, hold at LIMIT, clear has priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_cnt_en && (r_count != W'(LIMIT))) begin
         r_count <= r_count + W'(1);
      end
   end

endmodule

// File: rtl/pin_entry_collector.sv
// Keypad digit collector: buffers up to four digits and
// emits a one-cycle submit pulse on '*' for update_master.
module pin_entry_collector
   import pin_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 5000,
   parameter int unsigned TIMER_W        = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output pinPac_t    pin_out,
   output logic [2:0] digit_count,
   output logic       busy
);

   state_t     r_state;
   state_t     w_state_n;
   pinPac_t    r_pin;
   pinPac_t    w_pin_n;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_n;
   logic       r_busy;
   logic       w_accept;
   logic       w_expire;
   logic       w_digit;

   assign w_digit     = is_digit(key_code);
   assign pin_out     = r_pin;
   assign digit_count = r_cnt;
   assign busy        = r_busy;

   pin_idle_timer #(
      .LIMIT (TIMEOUT_CYCLES),
      .W     (TIMER_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_accept || (w_state_n != S_COLLECT)),
      .i_cnt_en (r_state == S_COLLECT),
      .o_expire (w_expire)
   );

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_pin   <= PIN_CLEAR;
         r_cnt   <= 3'd0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_pin   <= w_pin_n;
         r_cnt   <= w_cnt_n;
         r_busy  <= (w_state_n == S_COLLECT);
      end
   end

   // Next state, next buffer contents and timer restart.
   always_comb begin
      w_state_n      = r_state;
      w_pin_n        = r_pin;
      w_pin_n.status = 1'b0;
      w_cnt_n        = r_cnt;
      w_accept       = 1'b0;
      if (!enable) begin
         w_state_n = S_IDLE;
         w_pin_n   = PIN_CLEAR;
         w_cnt_n   = 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (key_valid && w_digit) begin
                  w_pin_n        = PIN_CLEAR;
                  w_pin_n.digit1 = key_code;
                  w_cnt_n        = 3'd1;
                  w_state_n      = S_COLLECT;
               end else if (key_valid && key_code == KEY_STAR) begin
                  w_pin_n        = PIN_CLEAR;
                  w_pin_n.status = 1'b1;
                  w_state_n      = S_SUBMIT;
               end
            end
            S_COLLECT: begin
               if (key_valid && w_digit) begin
                  w_accept = 1'b1;
                  case (r_cnt)
                     3'd1:    w_pin_n.digit2 = key_code;
                     3'd2:    w_pin_n.digit3 = key_code;
                     3'd3:    w_pin_n.digit4 = key_code;
                     default: begin
                        w_pin_n.digit1 = r_pin.digit2;
                        w_pin_n.digit2 = r_pin.digit3;
                        w_pin_n.digit3 = r_pin.digit4;
                        w_pin_n.digit4 = key_code;
                     end
                  endcase
                  if (r_cnt < 3'd4) w_cnt_n = r_cnt + 3'd1;
               end else if (key_valid && key_code == KEY_HASH) begin
                  w_accept  = 1'b1;
                  w_pin_n   = PIN_CLEAR;
                  w_cnt_n   = 3'd0;
                  w_state_n = S_IDLE;
               end else if (key_valid && key_code == KEY_STAR) begin
                  w_accept       = 1'b1;
                  w_pin_n.status = 1'b1;
                  w_state_n      = S_SUBMIT;
               end else if (w_expire) begin
                  w_pin_n   = PIN_CLEAR;
                  w_cnt_n   = 3'd0;
                  w_state_n = S_IDLE;
               end
            end
            default: begin
               w_pin_n   = PIN_CLEAR;
               w_cnt_n   = 3'd0;
               w_state_n = S_IDLE;
            end
         endcase
      end
   end

endmodule
